glow_ramp_sequencer: RTL and testbench



---
 rtl/glow_ramp_sequencer_if.sv | 25 ++
 rtl/glow_ramp_sequencer.sv | 151 +++++++++++++++
 tb/tb_glow_ramp_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/glow_ramp_sequencer_if.sv
// Control and status bundle between the glow ramp sequencer and its controller.
// The slave side is the sequencer; the master side sets enable/mode and watches the level.
interface glow_ramp_sequencer_if;
    logic       enable;
    logic       mode;
    logic [3:0] level;
    logic       busy;
    logic       cycle_done;

    modport master (
        output enable,
        output mode,
        input  level,
        input  busy,
        input  cycle_done
    );

    modport slave (
        input  enable,
        input  mode,
        output level,
        output busy,
        output cycle_done
    );
endinterface

// File: rtl/glow_ramp_sequencer.sv
// Breathing-brightness sequencer: a prescaled tick walks a 4-bit level up to 15, holds,
// returns to 0 (triangle or sawtooth), holds again, and repeats while enabled.
module glow_ramp_sequencer #(
    parameter int STEP_DIV    = 1500000,
    parameter int HOLD_TOP    = 8,
    parameter int HOLD_BOTTOM = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    glow_ramp_sequencer_if.slave  bus
);

    localparam int PW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HOLD_MAX = (HOLD_TOP > HOLD_BOTTOM) ? HOLD_TOP : HOLD_BOTTOM;
    localparam int HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0] TOP_LAST = (HOLD_TOP > 0)    ? HW'(HOLD_TOP - 1)    : '0;
    localparam logic [HW-1:0] BOT_LAST = (HOLD_BOTTOM > 0) ? HW'(HOLD_BOTTOM - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        RISE,
        HOLD_HI,
        FALL,
        HOLD_LO
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    level_q, level_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          done_q, done_d;
    logic          tick;
    logic          top_exit;
    logic          bottom_hit;

    assign tick = (state_q != IDLE) && (pre_q == PRE_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            level_q <= '0;
            pre_q   <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            pre_q   <= pre_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        pre_d      = pre_q;
        hold_d     = hold_q;
        done_d     = 1'b0;
        top_exit   = 1'b0;
        bottom_hit = 1'b0;

        if (state_q != IDLE)
            pre_d = tick ? '0 : pre_q + 1'b1;

        case (state_q)
            IDLE: begin
                level_d = '0;
                pre_d   = '0;
                hold_d  = '0;
                if (bus.enable)
                    state_d = RISE;
            end
            RISE: begin
                if (tick) begin
                    level_d = (level_q == 4'd15) ? level_q : level_q + 4'd1;
                    if (level_q == 4'd14) begin
                        if (HOLD_TOP > 0)
                            state_d = HOLD_HI;
                        else
                            top_exit = 1'b1;
                    end
                end
            end
            HOLD_HI: begin
                level_d = 4'd15;
                if (tick && hold_q == TOP_LAST)
                    top_exit = 1'b1;
            end
            FALL: begin
                if (tick) begin
                    level_d = (level_q == 4'd0) ? level_q : level_q - 4'd1;
                    if (level_q == 4'd1)
                        bottom_hit = 1'b1;
                end
            end
            HOLD_LO: begin
                level_d = '0;
                if (tick && hold_q == BOT_LAST) begin
                    state_d = RISE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                level_d = '0;
            end
        endcase

        // Mode is only looked at on the edge that leaves the top of the ramp.
        if (top_exit) begin
            if (!bus.mode) begin
                state_d = FALL;
                level_d = 4'd15;
            end else begin
                bottom_hit = 1'b1;
            end
        end

        if (bottom_hit) begin
            level_d = '0;
            if (HOLD_BOTTOM > 0) begin
                state_d = HOLD_LO;
            end else begin
                state_d = RISE;
                done_d  = 1'b1;
            end
        end

        if (state_d != state_q)
            hold_d = '0;
        else if (tick && (state_q == HOLD_HI || state_q == HOLD_LO))
            hold_d = hold_q + 1'b1;

        // Disable wins over any tick or completion in the same cycle.
        if (state_q != IDLE && !bus.enable) begin
            state_d = IDLE;
            level_d = '0;
            pre_d   = '0;
            hold_d  = '0;
            done_d  = 1'b0;
        end
    end

    assign bus.level      = level_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.cycle_done = done_q;

endmodule

// File: tb/tb_glow_ramp_sequencer.sv
// Scoreboard bench: three sequencer configurations driven with random enable/mode,
// checked every cycle against a period-position model of the breathing waveform.
module tb_glow_ramp_sequencer;

    localparam int N = 3;

    typedef struct packed {
        logic [3:0] lvl;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    logic en [N];
    logic md [N];
    logic [3:0] lv [N];
    logic bz [N];
    logic dn [N];

    int sd [N] = '{3, 1, 4};
    int ht [N] = '{2, 0, 2};
    int hb [N] = '{1, 0, 1};

    int run [N];
    int cnt [N];
    int pos [N];
    int tmode [N];
    logic [3:0] cur [N];

    exp_t sbq [$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    glow_ramp_sequencer_if bus0 ();
    glow_ramp_sequencer_if bus1 ();
    glow_ramp_sequencer_if bus2 ();

    assign bus0.enable = en[0];
    assign bus0.mode   = md[0];
    assign bus1.enable = en[1];
    assign bus1.mode   = md[1];
    assign bus2.enable = en[2];
    assign bus2.mode   = md[2];

    assign lv[0] = bus0.level;  assign bz[0] = bus0.busy;  assign dn[0] = bus0.cycle_done;
    assign lv[1] = bus1.level;  assign bz[1] = bus1.busy;  assign dn[1] = bus1.cycle_done;
    assign lv[2] = bus2.level;  assign bz[2] = bus2.busy;  assign dn[2] = bus2.cycle_done;

    glow_ramp_sequencer #(.STEP_DIV(3), .HOLD_TOP(2), .HOLD_BOTTOM(1))
        dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
    glow_ramp_sequencer #(.STEP_DIV(1), .HOLD_TOP(0), .HOLD_BOTTOM(0))
        dut1 (.clk(clk), .resetn(resetn), .bus(bus1));
    glow_ramp_sequencer #(.STEP_DIV(4), .HOLD_TOP(2), .HOLD_BOTTOM(1))
        dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

    function automatic int period(input int i);
        return (tmode[i] != 0 ? 15 : 30) + ht[i] + hb[i];
    endfunction

    // Level as a function of tick position within the current period.
    function automatic logic [3:0] lvl_of(input int i);
        int p;
        int top;
        int d;
        p   = pos[i];
        top = 15 + ht[i];
        if (p < top) return 4'((p > 15) ? 15 : p);
        if (tmode[i] != 0) return 4'd0;
        d = 15 - (p - top);
        return 4'((d < 0) ? 0 : d);
    endfunction

    task automatic step(input int i, input logic e, input logic m, output exp_t x);
        x = '0;
        if (run[i] == 0) begin
            if (e) begin
                run[i] = 1;
                cnt[i] = 0;
                pos[i] = 0;
                x.busy = 1'b1;
            end
        end else if (!e) begin
            run[i] = 0;
        end else begin
            x.busy = 1'b1;
            if (cnt[i] == sd[i] - 1) begin
                cnt[i] = 0;
                pos[i]++;
                if (pos[i] == 15 + ht[i]) tmode[i] = m ? 1 : 0;
                if (pos[i] == period(i)) begin
                    pos[i] = 0;
                    x.done = 1'b1;
                end
            end else begin
                cnt[i]++;
            end
            x.lvl = lvl_of(i);
        end
        cur[i] = x.lvl;
    endtask

    task automatic do_cycle();
        exp_t x;
        for (int i = 0; i < N; i++) begin
            step(i, en[i], md[i], x);
            sbq.push_back(x);
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            n_tests++;
            if ({lv[i], bz[i], dn[i]} != 6'b0) begin
                n_fail++;
                $display("FAIL %s inst%0d: level=%0d busy=%0b done=%0b, required all zero",
                         tag, i, lv[i], bz[i], dn[i]);
            end
        end
    endtask

    task automatic bound_fail(input string tag);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at cycle %0d, required condition reached", tag, cyc);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sbq.size() >= N) begin
            for (int i = 0; i < N; i++) begin
                x = sbq.pop_front();
                n_tests++;
                if ({lv[i], bz[i], dn[i]} !== x) begin
                    n_fail++;
                    $display("FAIL out inst%0d cyc %0d: level=%0d busy=%0b done=%0b, required level=%0d busy=%0b done=%0b",
                             i, cyc, lv[i], bz[i], dn[i], x.lvl, x.busy, x.done);
                end
            end
        end
    end

    initial begin
        int guard;
        resetn = 1'b1;
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b0; md[i] = 1'b0;
            run[i] = 0; cnt[i] = 0; pos[i] = 0; tmode[i] = 0; cur[i] = '0;
        end
        #2 resetn = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        repeat (5) do_cycle();
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        repeat (400) do_cycle();

        for (int i = 0; i < N; i++) md[i] = 1'b1;
        repeat (200) do_cycle();

        // Asynchronous reset in the middle of a rise.
        for (int i = 0; i < N; i++) md[i] = 1'b0;
        guard = 0;
        while (!(run[0] != 0 && cur[0] == 4'd7 && pos[0] < 15) && guard < 600) begin
            do_cycle();
            guard++;
        end
        if (guard >= 600) bound_fail("reset_wait");
        resetn = 1'b0;
        #1 check_zero("async_reset");
        for (int i = 0; i < N; i++) run[i] = 0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (60) do_cycle();

        // Mode raised during the top hold: next exit must drop straight to 0.
        guard = 0;
        while (!(run[0] != 0 && pos[0] >= 15 && pos[0] < 15 + ht[0]) && guard < 600) begin
            do_cycle();
            guard++;
        end
        if (guard >= 600) bound_fail("hold_hi_wait");
        md[0] = 1'b1;
        repeat (40) do_cycle();
        md[0] = 1'b0;

        // Mode raised mid-fall: the fall must finish normally.
        guard = 0;
        while (!(run[0] != 0 && tmode[0] == 0 && pos[0] > 15 + ht[0] && cur[0] > 4'd3) && guard < 600) begin
            do_cycle();
            guard++;
        end
        if (guard >= 600) bound_fail("fall_wait");
        md[0] = 1'b1;
        repeat (60) do_cycle();
        md[0] = 1'b0;

        // Disable on the very edge that would finish the bottom hold.
        for (int k = 0; k < 3; k++) begin
            guard = 0;
            while (!(run[0] != 0 && pos[0] > 15 + ht[0] && pos[0] == period(0) - 1 &&
                     cnt[0] == sd[0] - 1) && guard < 600) begin
                do_cycle();
                guard++;
            end
            if (guard >= 600) bound_fail("disable_wait");
            en[0] = 1'b0;
            do_cycle();
            en[0] = 1'b1;
            repeat (3) do_cycle();
        end

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                en[i] = ($urandom_range(0, 149) != 0);
                if ($urandom_range(0, 24) == 0) md[i] = ~md[i];
            end
            do_cycle();
        end

        @(negedge clk);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
